// File: rtl/video_timing_if.sv
// Raster timing bundle: pixel-enable and mode request in, counters and aligned strobes out.
// The generator drives the slave side; the display stage or a bench drives the master side.
interface video_timing_if;
  logic        pix_ce;
  logic        ntsc;
  logic [10:0] h_pixel;
  logic [10:0] v_pixel;
  logic        enable_pixel;
  logic        hsync;
  logic        vsync;
  logic        hsync_pin;
  logic        vsync_pin;
  logic        frame_start;
  logic        ntsc_active;

  modport master (
    output pix_ce, ntsc,
    input  h_pixel, v_pixel, enable_pixel, hsync, vsync,
    input  hsync_pin, vsync_pin, frame_start, ntsc_active
  );

  modport slave (
    input  pix_ce, ntsc,
    output h_pixel, v_pixel, enable_pixel, hsync, vsync,
    output hsync_pin, vsync_pin, frame_start, ntsc_active
  );
endinterface

// File: rtl/video_timing.sv
// VGA/NTSC raster generator: counters, pixel-enable and syncs all registered together (zero skew).
// Advances only on pix_ce; no backpressure. Mode request is sampled only at the (0,0) wrap.
module video_timing #(
  parameter int unsigned H_VIS         = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_VIS         = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter int unsigned N_VIS         = 240,
  parameter int unsigned N_FP          = 3,
  parameter int unsigned N_SYNC        = 3,
  parameter int unsigned N_BP          = 16,
  parameter bit          HS_ACTIVE_LOW = 1'b1,
  parameter bit          VS_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          res_n,
  video_timing_if.slave vt
);

  localparam logic [10:0] H_TOTAL  = 11'(H_VIS + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
  localparam logic [10:0] HS_BEG   = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] V_TOTAL  = 11'(V_VIS + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
  localparam logic [10:0] VS_BEG_V = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END_V = 11'(V_VIS + V_FP + V_SYNC);
  localparam logic [10:0] N_TOTAL  = 11'(N_VIS + N_FP + N_SYNC + N_BP);
  localparam logic [10:0] N_VIS_W  = 11'(N_VIS);
  localparam logic [10:0] VS_BEG_N = 11'(N_VIS + N_FP);
  localparam logic [10:0] VS_END_N = 11'(N_VIS + N_FP + N_SYNC);

  logic [10:0] r_h_pixel;
  logic [10:0] r_v_pixel;
  logic        r_enable_pixel;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hsync_pin;
  logic        r_vsync_pin;
  logic        r_frame_start;
  logic        r_ntsc_active;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_v_total;
  logic [10:0] w_h_next;
  logic [10:0] w_v_next;
  logic        w_ntsc_next;
  logic [10:0] w_vis;
  logic [10:0] w_vs_beg;
  logic [10:0] w_vs_end;
  logic        w_en_next;
  logic        w_hs_next;
  logic        w_vs_next;

  assign w_h_wrap    = (r_h_pixel == H_TOTAL - 11'd1);
  assign w_v_total   = r_ntsc_active ? N_TOTAL : V_TOTAL;
  assign w_v_wrap    = w_h_wrap && (r_v_pixel == w_v_total - 11'd1);
  assign w_h_next    = w_h_wrap ? 11'd0 : r_h_pixel + 11'd1;
  assign w_v_next    = !w_h_wrap ? r_v_pixel : (w_v_wrap ? 11'd0 : r_v_pixel + 11'd1);
  assign w_ntsc_next = w_v_wrap ? vt.ntsc : r_ntsc_active;

  // Flags decode the post-update counters in the post-update mode, so they never lag the counters.
  assign w_vis     = w_ntsc_next ? N_VIS_W  : V_VIS_W;
  assign w_vs_beg  = w_ntsc_next ? VS_BEG_N : VS_BEG_V;
  assign w_vs_end  = w_ntsc_next ? VS_END_N : VS_END_V;
  assign w_en_next = (w_h_next < H_VIS_W) && (w_v_next < w_vis);
  assign w_hs_next = (w_h_next >= HS_BEG) && (w_h_next < HS_END);
  assign w_vs_next = (w_v_next >= w_vs_beg) && (w_v_next < w_vs_end);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_h_pixel      <= H_TOTAL - 11'd1;
      r_v_pixel      <= V_TOTAL - 11'd1;
      r_enable_pixel <= 1'b0;
      r_hsync        <= 1'b0;
      r_vsync        <= 1'b0;
      r_hsync_pin    <= HS_ACTIVE_LOW;
      r_vsync_pin    <= VS_ACTIVE_LOW;
      r_frame_start  <= 1'b0;
      r_ntsc_active  <= 1'b0;
    end else if (vt.pix_ce) begin
      r_h_pixel      <= w_h_next;
      r_v_pixel      <= w_v_next;
      r_enable_pixel <= w_en_next;
      r_hsync        <= w_hs_next;
      r_vsync        <= w_vs_next;
      r_hsync_pin    <= w_hs_next ^ HS_ACTIVE_LOW;
      r_vsync_pin    <= w_vs_next ^ VS_ACTIVE_LOW;
      r_frame_start  <= w_v_wrap;
      r_ntsc_active  <= w_ntsc_next;
    end else begin
      r_frame_start  <= 1'b0;
    end
  end

  assign vt.h_pixel      = r_h_pixel;
  assign vt.v_pixel      = r_v_pixel;
  assign vt.enable_pixel = r_enable_pixel;
  assign vt.hsync        = r_hsync;
  assign vt.vsync        = r_vsync;
  assign vt.hsync_pin    = r_hsync_pin;
  assign vt.vsync_pin    = r_vsync_pin;
  assign vt.frame_start  = r_frame_start;
  assign vt.ntsc_active  = r_ntsc_active;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a full-size VGA instance for line-level timing and a scaled
// instance (16x12 VGA / 16x9 NTSC, non-inverted hsync pin) for frame-level behaviour.
module tb_video_timing;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        en;
    logic        hs;
    logic        vs;
    logic        hsp;
    logic        vsp;
    logic        fs;
    logic        na;
  } obs_t;

  // kind 0: compare outputs; 1: compare window counts since last mark; 2: set mark
  typedef struct {
    int    kind;
    int    seq;
    string nm;
    obs_t  o;
    int    e_en;
    int    e_hs;
    int    e_vs;
    int    e_gap;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n0;
  logic rst_n1;
  always #5 clk = ~clk;

  video_timing_if vif0 ();
  video_timing_if vif1 ();

  video_timing u_vga (
    .clk   (clk),
    .res_n (rst_n0),
    .vt    (vif0)
  );

  video_timing #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .N_VIS(4), .N_FP(1), .N_SYNC(3), .N_BP(1),
    .HS_ACTIVE_LOW(1'b0), .VS_ACTIVE_LOW(1'b1)
  ) u_small (
    .clk   (clk),
    .res_n (rst_n1),
    .vt    (vif1)
  );

  ent_t q0[$];
  ent_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   out_cnt[2];
  int   tot[2];
  int   en_tot[2];
  int   hs_tot[2];
  int   vs_tot[2];
  int   m_en[2];
  int   m_hs[2];
  int   m_vs[2];
  int   fs_last[2];
  int   fs_gap[2];
  bit   adv[2];
  bit   prv_ok[2];
  obs_t prv[2];
  bit   fin      = 1'b0;
  bit   fin_done = 1'b0;

  function automatic obs_t mk(input int h, input int v, input bit en, input bit hs, input bit vs,
                              input bit hsp, input bit vsp, input bit fs, input bit na);
    obs_t o;
    o.h = 11'(h); o.v = 11'(v); o.en = en; o.hs = hs; o.vs = vs;
    o.hsp = hsp; o.vsp = vsp; o.fs = fs; o.na = na;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("h=%0d v=%0d en=%0b hs=%0b vs=%0b hsp=%0b vsp=%0b fs=%0b na=%0b",
                     o.h, o.v, o.en, o.hs, o.vs, o.hsp, o.vsp, o.fs, o.na);
  endfunction

  function automatic obs_t smp(input int i);
    obs_t o;
    if (i == 0)
      o = {vif0.h_pixel, vif0.v_pixel, vif0.enable_pixel, vif0.hsync, vif0.vsync,
           vif0.hsync_pin, vif0.vsync_pin, vif0.frame_start, vif0.ntsc_active};
    else
      o = {vif1.h_pixel, vif1.v_pixel, vif1.enable_pixel, vif1.hsync, vif1.vsync,
           vif1.hsync_pin, vif1.vsync_pin, vif1.frame_start, vif1.ntsc_active};
    return o;
  endfunction

  // Reference for the scaled instance in VGA mode: position n (0-based) after reset release.
  function automatic obs_t model_small_vga(input int n);
    int h;
    int v;
    bit hs;
    bit vs;
    h  = n % 16;
    v  = (n / 16) % 12;
    hs = (h >= 10) && (h < 13);
    vs = (v >= 8) && (v < 10);
    return mk(h, v, (h < 8) && (v < 6), hs, vs, hs, !vs, (n % 192) == 0, 1'b0);
  endfunction

  task automatic push_ent(input int i, input ent_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_obs(input int i, input int seq, input string nm, input obs_t o);
    ent_t e;
    e.kind = 0; e.seq = seq; e.nm = nm; e.o = o;
    e.e_en = 0; e.e_hs = 0; e.e_vs = 0; e.e_gap = -1;
    push_ent(i, e);
  endtask

  task automatic push_mark(input int i, input int seq);
    ent_t e;
    e.kind = 2; e.seq = seq; e.nm = "mark"; e.o = '0;
    e.e_en = 0; e.e_hs = 0; e.e_vs = 0; e.e_gap = -1;
    push_ent(i, e);
  endtask

  task automatic push_agg(input int i, input int seq, input string nm,
                          input int en, input int hs, input int vs, input int gap);
    ent_t e;
    e.kind = 1; e.seq = seq; e.nm = nm; e.o = '0;
    e.e_en = en; e.e_hs = hs; e.e_vs = vs; e.e_gap = gap;
    push_ent(i, e);
  endtask

  task automatic chk_obs(input string nm, input int i, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %s, want %s", nm, i, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk_int(input string nm, input int i, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d, want %0d", nm, i, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qseq(input int i);
    return (i == 0) ? q0[0].seq : q1[0].seq;
  endfunction

  task automatic mon_step(input int i);
    obs_t cur;
    obs_t hold;
    ent_t e;
    bit   rn;
    cur = smp(i);
    rn  = (i == 0) ? rst_n0 : rst_n1;
    if (!rn) begin
      out_cnt[i] = 0;
    end else if (adv[i]) begin
      out_cnt[i]++;
      tot[i]++;
      en_tot[i] += int'(cur.en);
      hs_tot[i] += int'(cur.hs);
      vs_tot[i] += int'(cur.vs);
      if (cur.fs) begin
        fs_gap[i]  = tot[i] - fs_last[i];
        fs_last[i] = tot[i];
      end
    end else if (prv_ok[i]) begin
      hold    = prv[i];
      hold.fs = 1'b0;
      chk_obs("hold_no_ce", i, cur, hold);
    end
    prv[i]    = cur;
    prv_ok[i] = rn;
    while (qsize(i) > 0 && qseq(i) <= out_cnt[i]) begin
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      case (e.kind)
        0: chk_obs(e.nm, i, cur, e.o);
        1: begin
          chk_int({e.nm, "_en_count"}, i, en_tot[i] - m_en[i], e.e_en);
          chk_int({e.nm, "_hs_count"}, i, hs_tot[i] - m_hs[i], e.e_hs);
          chk_int({e.nm, "_vs_count"}, i, vs_tot[i] - m_vs[i], e.e_vs);
          if (e.e_gap >= 0) chk_int({e.nm, "_fs_period"}, i, fs_gap[i], e.e_gap);
        end
        default: begin
          m_en[i] = en_tot[i];
          m_hs[i] = hs_tot[i];
          m_vs[i] = vs_tot[i];
        end
      endcase
    end
  endtask

  task automatic flush(input int i);
    ent_t e;
    while (qsize(i) > 0) begin
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s inst%0d: expected output %0d never reached, outputs seen %0d",
               e.nm, i, e.seq, out_cnt[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      out_cnt[i] = 0; tot[i] = 0; en_tot[i] = 0; hs_tot[i] = 0; vs_tot[i] = 0;
      m_en[i] = 0; m_hs[i] = 0; m_vs[i] = 0; fs_last[i] = 0; fs_gap[i] = 0;
      adv[i] = 1'b0; prv_ok[i] = 1'b0; prv[i] = '0;
    end
  end

  always @(posedge clk) begin
    adv[0] = rst_n0 && vif0.pix_ce;
    adv[1] = rst_n1 && vif1.pix_ce;
  end

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
    if (fin && !fin_done) begin
      flush(0);
      flush(1);
      fin_done = 1'b1;
    end
  end

  task automatic set_ce(input int i, input logic v);
    if (i == 0) vif0.pix_ce = v;
    else        vif1.pix_ce = v;
  endtask

  task automatic set_rst(input int i, input logic v);
    if (i == 0) rst_n0 = v;
    else        rst_n1 = v;
  endtask

  // n back-to-back pix_ce; returns just after the monitor has seen the last result.
  task automatic run(input int i, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      set_ce(i, 1'b1);
    end
    @(posedge clk); #1;
    set_ce(i, 1'b0);
    @(negedge clk); #1;
  endtask

  // One-clock async reset pulse, then one pix_ce; recovery entry checked on that output.
  task automatic pulse_reset(input int i, input obs_t rst_val, input obs_t first_val);
    @(posedge clk); #1;
    set_rst(i, 1'b0);
    set_ce(i, 1'b1);
    push_obs(i, 0, "reset_mid_run", rst_val);
    @(posedge clk); #1;
    set_rst(i, 1'b1);
    push_obs(i, 1, "reset_recover", first_val);
    @(posedge clk); #1;
    set_ce(i, 1'b0);
    @(negedge clk); #1;
  endtask

  initial begin
    obs_t rst_a;
    obs_t rst_b;
    int   cnt;
    bit   b;
    rst_a = mk(799, 524, 0, 0, 0, 1, 1, 0, 0);
    rst_b = mk(15, 11, 0, 0, 0, 0, 1, 0, 0);
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    vif0.pix_ce = 1'b1; vif0.ntsc = 1'b0;
    vif1.pix_ce = 1'b1; vif1.ntsc = 1'b0;

    // Reset state, held while pix_ce toggles high
    push_obs(0, 0, "reset_state", rst_a);
    push_obs(1, 0, "reset_state", rst_b);
    repeat (3) @(negedge clk);
    #1;
    push_obs(0, 0, "reset_held_ce", rst_a);
    push_obs(1, 0, "reset_held_ce", rst_b);
    @(posedge clk); #1;
    set_ce(0, 1'b0); set_ce(1, 1'b0);
    @(negedge clk); #1;
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    // Full-size VGA: first output and one complete line
    push_obs(0, 1, "first_ce_origin", mk(0, 0, 1, 0, 0, 1, 1, 1, 0));
    run(0, 1);
    push_mark(0, 1);
    push_obs(0, 640, "h639_visible",   mk(639, 0, 1, 0, 0, 1, 1, 0, 0));
    push_obs(0, 641, "h640_blank",     mk(640, 0, 0, 0, 0, 1, 1, 0, 0));
    push_obs(0, 656, "h655_pre_hsync", mk(655, 0, 0, 0, 0, 1, 1, 0, 0));
    push_obs(0, 657, "h656_hsync_on",  mk(656, 0, 0, 1, 0, 0, 1, 0, 0));
    push_obs(0, 752, "h751_hsync_end", mk(751, 0, 0, 1, 0, 0, 1, 0, 0));
    push_obs(0, 753, "h752_hsync_off", mk(752, 0, 0, 0, 0, 1, 1, 0, 0));
    push_obs(0, 800, "h799_line_end",  mk(799, 0, 0, 0, 0, 1, 1, 0, 0));
    push_obs(0, 801, "line1_start",    mk(0, 1, 1, 0, 0, 1, 1, 0, 0));
    push_agg(0, 801, "vga_line", 640, 96, 0, -1);
    run(0, 800);

    // Full-size VGA: reset pulse mid-line
    push_obs(0, 1101, "h300_v1", mk(300, 1, 1, 0, 0, 1, 1, 0, 0));
    run(0, 300);
    pulse_reset(0, rst_a, mk(0, 0, 1, 0, 0, 1, 1, 1, 0));

    // Scaled instance: VGA frame timing
    push_obs(1, 1, "first_ce_origin", mk(0, 0, 1, 0, 0, 0, 1, 1, 0));
    run(1, 1);
    push_mark(1, 1);
    push_obs(1, 128, "v7_last_pre_vs", mk(15, 7, 0, 0, 0, 0, 1, 0, 0));
    push_obs(1, 129, "v8_vsync_on",    mk(0, 8, 0, 0, 1, 0, 0, 0, 0));
    push_obs(1, 139, "v8_h10_hsync",   mk(10, 8, 0, 1, 1, 1, 0, 0, 0));
    push_obs(1, 160, "v9_vsync_last",  mk(15, 9, 0, 0, 1, 0, 0, 0, 0));
    push_obs(1, 161, "v10_vsync_off",  mk(0, 10, 0, 0, 0, 0, 1, 0, 0));
    push_obs(1, 192, "vga_frame_end",  mk(15, 11, 0, 0, 0, 0, 1, 0, 0));
    push_obs(1, 193, "vga_frame_wrap", mk(0, 0, 1, 0, 0, 0, 1, 1, 0));
    push_agg(1, 193, "vga_frame", 48, 36, 32, 192);
    run(1, 192);

    // Mode request mid-frame takes effect only at the next wrap
    run(1, 48);
    vif1.ntsc = 1'b1;
    push_obs(1, 321, "vga_vs_kept",   mk(0, 8, 0, 0, 1, 0, 0, 0, 0));
    push_obs(1, 384, "vga_full_end",  mk(15, 11, 0, 0, 0, 0, 1, 0, 0));
    push_obs(1, 385, "ntsc_start",    mk(0, 0, 1, 0, 0, 0, 1, 1, 1));
    push_mark(1, 385);
    push_obs(1, 440, "ntsc_v3_h7",    mk(7, 3, 1, 0, 0, 0, 1, 0, 1));
    push_obs(1, 449, "ntsc_v4_blank", mk(0, 4, 0, 0, 0, 0, 1, 0, 1));
    push_obs(1, 465, "ntsc_vs_on",    mk(0, 5, 0, 0, 1, 0, 0, 0, 1));
    push_obs(1, 475, "ntsc_vs_hs",    mk(10, 5, 0, 1, 1, 1, 0, 0, 1));
    push_obs(1, 512, "ntsc_vs_last",  mk(15, 7, 0, 0, 1, 0, 0, 0, 1));
    push_obs(1, 513, "ntsc_vs_off",   mk(0, 8, 0, 0, 0, 0, 1, 0, 1));
    push_obs(1, 528, "ntsc_end",      mk(15, 8, 0, 0, 0, 0, 1, 0, 1));
    push_obs(1, 529, "ntsc_wrap",     mk(0, 0, 1, 0, 0, 0, 1, 1, 1));
    push_agg(1, 529, "ntsc_frame", 32, 27, 48, 144);
    run(1, 288);

    // Reset while NTSC is active; ntsc request stays high across the reset
    push_obs(1, 582, "ntsc_pre_reset", mk(5, 3, 1, 0, 0, 0, 1, 0, 1));
    run(1, 53);
    pulse_reset(1, rst_b, mk(0, 0, 1, 0, 0, 0, 1, 1, 1));
    vif1.ntsc = 1'b0;
    push_obs(1, 144, "ntsc_after_rst_end", mk(15, 8, 0, 0, 0, 0, 1, 0, 1));
    push_obs(1, 145, "back_to_vga",        mk(0, 0, 1, 0, 0, 0, 1, 1, 0));
    run(1, 144);

    // Stalled pix_ce stream against the gap-free reference positions
    @(posedge clk); #1;
    rst_n1 = 1'b0;
    push_obs(1, 0, "reset_before_gaps", rst_b);
    repeat (2) @(posedge clk);
    #1;
    rst_n1 = 1'b1;
    for (int s = 1; s <= 384; s++) push_obs(1, s, "gap_stream", model_small_vga(s - 1));
    cnt = 0;
    for (int k = 0; k < 4000 && cnt < 384; k++) begin
      @(posedge clk); #1;
      b = ($urandom_range(0, 1) == 1) && ($urandom_range(0, 7) != 0);
      vif1.pix_ce = b;
      if (b) cnt++;
    end
    @(posedge clk); #1;
    vif1.pix_ce = 1'b0;
    repeat (4) @(negedge clk);
    #1;

    fin = 1'b1;
    for (int k = 0; k < 10 && !fin_done; k++) @(negedge clk);
    #1;
    if (!fin_done) $fatal(1, "FAIL monitor_flush: monitor did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
